// File: rtl/alu_share_sched_if.sv
// Command, response and ALU-side signal bundle for alu_share_sched.
// slave = scheduler side; master = requesters plus the ALU instance.
interface alu_share_sched_if #(
    parameter int DW = 8
);
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic [1:0]    req0_sel;
    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic [1:0]    req1_sel;
    logic          rsp0_valid;
    logic          rsp0_ready;
    logic          rsp1_valid;
    logic          rsp1_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_carry;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_sel;
    logic [DW-1:0] alu_out;
    logic          alu_carry;
    logic          busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  rsp0_ready, rsp1_ready, alu_out, alu_carry,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_data, rsp_carry, alu_a, alu_b, alu_sel, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output rsp0_ready, rsp1_ready, alu_out, alu_carry,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_data, rsp_carry, alu_a, alu_b, alu_sel, busy
    );
endinterface

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one pipelined ALU between two requesters.
// Optional per-requester grant counters when ALU_SCHED_STATS_EN is defined.
module alu_share_sched #(
    parameter int DW      = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    alu_share_sched_if.slave bus
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [1:0]    alu_sel_q, alu_sel_d;
    logic [DW-1:0] data_q, data_d;
    logic          carry_q, carry_d;
    logic          win0, win1, acc0, acc1, rsp_hs;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        win0   = bus.req0_valid & (~bus.req1_valid | last_q);
        win1   = bus.req1_valid & (~bus.req0_valid | ~last_q);
        acc0   = (state_q == IDLE) & wb_rst_n & win0;
        acc1   = (state_q == IDLE) & wb_rst_n & win1;
        rsp_hs = (state_q == RESP) & (gnt_q ? bus.rsp1_ready : bus.rsp0_ready);
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        data_d    = data_q;
        carry_d   = carry_q;
        case (state_q)
            IDLE: begin
                if (acc0 || acc1) begin
                    alu_a_d   = acc1 ? bus.req1_a   : bus.req0_a;
                    alu_b_d   = acc1 ? bus.req1_b   : bus.req0_b;
                    alu_sel_d = acc1 ? bus.req1_sel : bus.req0_sel;
                    gnt_d     = acc1;
                    last_d    = acc1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = WAIT;
            end
            // Operands are visible to the ALU from ISSUE, so its result is
            // valid in the ALU_LAT-th WAIT cycle, i.e. when the count hits 0.
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = bus.alu_out;
                    carry_d = bus.alu_carry;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            data_q    <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            data_q    <= data_d;
            carry_q   <= carry_d;
        end
    end

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.rsp0_valid = (state_q == RESP) & ~gnt_q;
    assign bus.rsp1_valid = (state_q == RESP) & gnt_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.busy       = (state_q != IDLE);

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] gcnt0_q, gcnt1_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            if (acc0 && gcnt0_q != '1) gcnt0_q <= gcnt0_q + 16'd1;
            if (acc1 && gcnt1_q != '1) gcnt1_q <= gcnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = gcnt0_q;
    assign grant_cnt1 = gcnt1_q;
`endif
endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched: ALU_LAT=1 instance for most cases,
// ALU_LAT=4 instance for the mid-operation reset case.
module tb_alu_share_sched;
    logic clk = 1'b0;
    logic rst1_n = 1'b0;
    logic rst4_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_sched_if #(.DW(8)) bus1 ();
    alu_share_sched_if #(.DW(8)) bus4 ();

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] gc0_1, gc1_1, gc0_4, gc1_4;
`endif

    alu_share_sched #(.DW(8), .ALU_LAT(1)) u_dut1 (
        .wb_clk_i (clk),
        .wb_rst_n (rst1_n),
        .bus      (bus1)
`ifdef ALU_SCHED_STATS_EN
        ,
        .grant_cnt0 (gc0_1),
        .grant_cnt1 (gc1_1)
`endif
    );

    alu_share_sched #(.DW(8), .ALU_LAT(4)) u_dut4 (
        .wb_clk_i (clk),
        .wb_rst_n (rst4_n),
        .bus      (bus4)
`ifdef ALU_SCHED_STATS_EN
        ,
        .grant_cnt0 (gc0_4),
        .grant_cnt1 (gc1_4)
`endif
    );

    // Reference ALU: 00 add, 01 sub, 10 and, 11 xor; carry is bit 8.
    function automatic logic [8:0] alu_f(input logic [7:0] a, b, input logic [1:0] sel);
        case (sel)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    logic [8:0] p1;
    logic [8:0] p4 [4];
    always @(posedge clk) begin
        p1 <= alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
        p4[0] <= alu_f(bus4.alu_a, bus4.alu_b, bus4.alu_sel);
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
    assign bus1.alu_out   = p1[7:0];
    assign bus1.alu_carry = p1[8];
    assign bus4.alu_out   = p4[3][7:0];
    assign bus4.alu_carry = p4[3][8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy1(input int id);
        return (id == 1) ? bus1.req1_ready : bus1.req0_ready;
    endfunction

    task automatic drive1(input int id, input logic v, input logic [7:0] a, b, input logic [1:0] sel);
        if (id == 1) begin
            bus1.req1_valid = v; bus1.req1_a = a; bus1.req1_b = b; bus1.req1_sel = sel;
        end else begin
            bus1.req0_valid = v; bus1.req0_a = a; bus1.req0_b = b; bus1.req0_sel = sel;
        end
    endtask

    task automatic reset_main();
        @(negedge clk);
        rst1_n = 1'b0;
        #1;
        check("rst busy",   bus1.busy,       0);
        check("rst rsp0v",  bus1.rsp0_valid, 0);
        check("rst rsp1v",  bus1.rsp1_valid, 0);
        check("rst data",   bus1.rsp_data,   0);
        check("rst alu_a",  bus1.alu_a,      0);
        check("rst alu_b",  bus1.alu_b,      0);
`ifdef ALU_SCHED_STATS_EN
        check("rst gcnt0",  gc0_1, 0);
        check("rst gcnt1",  gc1_1, 0);
`endif
        @(negedge clk);
        rst1_n = 1'b1;
    endtask

    task automatic run_op(input int id, input logic [7:0] a, b, input logic [1:0] sel, output int acc);
        int n = 0;
        @(negedge clk);
        drive1(id, 1'b1, a, b, sel);
        #1;
        while (rdy1(id) !== 1'b1 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("op ready", rdy1(id), 1);
        acc = cyc;
        @(negedge clk);
        drive1(id, 1'b0, a, b, sel);
    endtask

    task automatic wait_rsp(input int id, input logic [7:0] ed, input logic ec, input string tag);
        int n = 0;
        while (((id == 1) ? bus1.rsp1_valid : bus1.rsp0_valid) !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        check({tag, " rspv"},  (id == 1) ? bus1.rsp1_valid : bus1.rsp0_valid, 1);
        check({tag, " data"},  bus1.rsp_data,  ed);
        check({tag, " carry"}, bus1.rsp_carry, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, acc_prev, acc;
        logic seen;
        logic [7:0] t3a [3];
        logic [7:0] t3b [3];
        logic [7:0] t3r [3];
        logic       t3c [3];
        t3a = '{8'h03, 8'h7F, 8'hFE};
        t3b = '{8'h04, 8'h01, 8'h03};
        t3r = '{8'h07, 8'h80, 8'h01};
        t3c = '{1'b0,  1'b0,  1'b1};

        drive1(0, 1'b0, 8'h00, 8'h00, 2'b00);
        drive1(1, 1'b0, 8'h00, 8'h00, 2'b00);
        bus1.rsp0_ready = 1'b1; bus1.rsp1_ready = 1'b1;
        bus4.req0_valid = 1'b0; bus4.req0_a = '0; bus4.req0_b = '0; bus4.req0_sel = '0;
        bus4.req1_valid = 1'b0; bus4.req1_a = '0; bus4.req1_b = '0; bus4.req1_sel = '0;
        bus4.rsp0_ready = 1'b1; bus4.rsp1_ready = 1'b1;

        // 1: single op, ALU_LAT=1, exact cycle timing
        reset_main();
        @(negedge clk);
        drive1(0, 1'b1, 8'h0F, 8'h01, 2'b00);
        #1;
        check("t1 req0_ready", bus1.req0_ready, 1);
        check("t1 req1_ready", bus1.req1_ready, 0);
        @(negedge clk);
        drive1(0, 1'b0, 8'h0F, 8'h01, 2'b00);
        check("t1 alu_a", bus1.alu_a, 8'h0F);
        check("t1 alu_b", bus1.alu_b, 8'h01);
        check("t1 busy issue", bus1.busy, 1);
        check("t1 rsp0v T+1", bus1.rsp0_valid, 0);
        @(negedge clk);
        check("t1 rsp0v T+2", bus1.rsp0_valid, 0);
        @(negedge clk);
        check("t1 rsp0v T+3", bus1.rsp0_valid, 1);
        check("t1 data", bus1.rsp_data, 8'h10);
        check("t1 carry", bus1.rsp_carry, 0);
        @(negedge clk);
        check("t1 busy T+4", bus1.busy, 0);
        check("t1 rsp0v T+4", bus1.rsp0_valid, 0);

        // 2: both valid continuously, grants alternate starting with 0
        reset_main();
        @(negedge clk);
        drive1(0, 1'b1, 8'h10, 8'h20, 2'b00);
        drive1(1, 1'b1, 8'hFF, 8'h02, 2'b00);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (!(bus1.req0_ready || bus1.req1_ready) && n < 40) begin
                @(negedge clk); #1; n++;
            end
            check("t2 any ready", bus1.req0_ready | bus1.req1_ready, 1);
            check("t2 both ready", bus1.req0_ready & bus1.req1_ready, 0);
            check($sformatf("t2 grant%0d", k), bus1.req1_ready, k % 2);
            @(negedge clk);
            if (k % 2 == 0) wait_rsp(0, 8'h30, 1'b0, "t2 r0");
            else            wait_rsp(1, 8'h01, 1'b1, "t2 r1");
        end
        drive1(0, 1'b0, 8'h00, 8'h00, 2'b00);
        drive1(1, 1'b0, 8'h00, 8'h00, 2'b00);

        // 3: only req1, three ops, accepts spaced ALU_LAT+3
        acc_prev = 0;
        for (int i = 0; i < 3; i++) begin
            run_op(1, t3a[i], t3b[i], 2'b00, acc);
            check("t3 req0_ready", bus1.req0_ready, 0);
            if (i > 0) check("t3 spacing", acc - acc_prev, 4);
            acc_prev = acc;
            wait_rsp(1, t3r[i], t3c[i], "t3");
        end

        // 4: response stalled 5 cycles, req1 waiting
        bus1.rsp0_ready = 1'b0;
        @(negedge clk);
        drive1(0, 1'b1, 8'h80, 8'h80, 2'b00);
        drive1(1, 1'b1, 8'h20, 8'h22, 2'b00);
        #1;
        check("t4 req0_ready", bus1.req0_ready, 1);
        check("t4 req1_ready", bus1.req1_ready, 0);
        @(negedge clk);
        drive1(0, 1'b0, 8'h80, 8'h80, 2'b00);
        wait_rsp(0, 8'h00, 1'b1, "t4");
        for (int i = 0; i < 5; i++) begin
            check("t4 hold rsp0v", bus1.rsp0_valid, 1);
            check("t4 hold data", {bus1.rsp_carry, bus1.rsp_data}, 9'h100);
            check("t4 hold alu", {bus1.alu_a, bus1.alu_b, bus1.alu_sel}, 18'h20200);
            check("t4 hold req1_ready", bus1.req1_ready, 0);
            @(negedge clk);
        end
        bus1.rsp0_ready = 1'b1;
        #1;
        check("t4 req1_ready hs", bus1.req1_ready, 0);
        @(negedge clk);
        #1;
        check("t4 busy after", bus1.busy, 0);
        check("t4 req1 wins", bus1.req1_ready, 1);
        @(negedge clk);
        drive1(1, 1'b0, 8'h20, 8'h22, 2'b00);
        wait_rsp(1, 8'h42, 1'b0, "t4 r1");

        // 5: ALU_LAT=4 instance, reset in WAIT
        check("t5 rst busy", bus4.busy, 0);
        check("t5 rst alu_a", bus4.alu_a, 0);
        @(negedge clk);
        rst4_n = 1'b1;
        @(negedge clk);
        bus4.req0_valid = 1'b1; bus4.req0_a = 8'h01; bus4.req0_b = 8'h02; bus4.req0_sel = 2'b00;
        #1;
        check("t5 req0_ready", bus4.req0_ready, 1);
        @(negedge clk);
        bus4.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5 in wait busy", bus4.busy, 1);
        #2;
        rst4_n = 1'b0;
        #1;
        check("t5 async busy", bus4.busy, 0);
        check("t5 async rsp0v", bus4.rsp0_valid, 0);
        check("t5 async alu", {bus4.alu_a, bus4.alu_b}, 0);
        check("t5 async data", bus4.rsp_data, 0);
        @(negedge clk);
        rst4_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus4.rsp0_valid || bus4.rsp1_valid || bus4.busy) seen = 1'b1;
        end
        check("t5 no rsp", seen, 0);
        bus4.req0_valid = 1'b1; bus4.req0_a = 8'h05; bus4.req0_b = 8'h06; bus4.req0_sel = 2'b00;
        bus4.req1_valid = 1'b1; bus4.req1_a = 8'h09; bus4.req1_b = 8'h09; bus4.req1_sel = 2'b00;
        #1;
        check("t5 req0 wins", bus4.req0_ready, 1);
        check("t5 req1 loses", bus4.req1_ready, 0);
        t = cyc;
        @(negedge clk);
        bus4.req0_valid = 1'b0;
        bus4.req1_valid = 1'b0;
        n = 0;
        while (bus4.rsp0_valid !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        check("t5 rsp0v", bus4.rsp0_valid, 1);
        check("t5 latency", cyc - t, 6);
        check("t5 data", bus4.rsp_data, 8'h0B);
        check("t5 carry", bus4.rsp_carry, 0);

`ifdef ALU_SCHED_STATS_EN
        // 6: grant counters
        reset_main();
        for (int i = 0; i < 3; i++) begin
            run_op(0, 8'h01, 8'h01, 2'b00, acc);
            wait_rsp(0, 8'h02, 1'b0, "t6 r0");
        end
        for (int i = 0; i < 2; i++) begin
            run_op(1, 8'h02, 8'h02, 2'b00, acc);
            wait_rsp(1, 8'h04, 1'b0, "t6 r1");
        end
        @(negedge clk);
        check("t6 gcnt0", gc0_1, 3);
        check("t6 gcnt1", gc1_1, 2);
        reset_main();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
